// File: rtl/core_bus_responder.sv
// core_bus_responder
//   Target-side memory model for the core's fetch and mem request/response
//   channels. Each channel holds at most one outstanding request. The two
//   channels are arbitrated onto a single word-addressed RAM of 2^ADDR_W
//   32-bit words, and every accepted request gets exactly one response pulse
//   LATENCY cycles after it is granted.
//
//   Optional build macro: BUS_RESP_ROUNDROBIN_EN
//     defined   -> round-robin arbitration between the channels when both
//                  are eligible in the same cycle
//     undefined -> fixed priority, mem before fetch
//
// Parameters
//   ADDR_W   RAM word-address width (byte address bits [ADDR_W+1:2])
//   LATENCY  cycles from grant to response pulse, 1..15
//
// Ports
//   clk, rst                         clock, asynchronous active-high reset
//   fetch_request_enable             fetch request strobe
//   freq_mode/addr/wdata/wstrb       fetch request fields (mode 1 = write)
//   fetch_response_enable            one-cycle fetch response strobe
//   fresp_data                       fetch read data, 0 when strobe is low
//   mem_request_enable               mem request strobe
//   mreq_mode/addr/wdata/wstrb       mem request fields (mode 1 = write)
//   mem_response_enable              one-cycle mem response strobe
//   mresp_data                       mem read data, 0 when strobe is low
//   err_overlap                      sticky flag: request dropped because its
//                                    channel was already busy
module core_bus_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_request_enable,
  input  logic        freq_mode,
  input  logic [31:0] freq_addr,
  input  logic [31:0] freq_wdata,
  input  logic [3:0]  freq_wstrb,
  output logic        fetch_response_enable,
  output logic [31:0] fresp_data,
  input  logic        mem_request_enable,
  input  logic        mreq_mode,
  input  logic [31:0] mreq_addr,
  input  logic [31:0] mreq_wdata,
  input  logic [3:0]  mreq_wstrb,
  output logic        mem_response_enable,
  output logic [31:0] mresp_data,
  output logic        err_overlap
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Value loaded into the wait counter at grant; unused when LATENCY is 1.
  localparam int         CNT_INIT_I = (LATENCY >= 2) ? (LATENCY - 2) : 0;
  localparam logic [3:0] CNT_INIT   = CNT_INIT_I[3:0];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gnt_mem_q, gnt_mem_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Per-channel pending request registers. The pending flag stays set from
  // acceptance through the response cycle, so it also marks "in service".
  logic        f_pend_q, f_pend_d;
  logic        f_mode_q, f_mode_d;
  logic [31:0] f_addr_q, f_addr_d;
  logic [31:0] f_wdata_q, f_wdata_d;
  logic [3:0]  f_wstrb_q, f_wstrb_d;

  logic        m_pend_q, m_pend_d;
  logic        m_mode_q, m_mode_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [3:0]  m_wstrb_q, m_wstrb_d;

  logic [31:0] ram_mem [2**ADDR_W];

  logic        f_accept, m_accept;
  logic        f_elig, m_elig;
  logic        f_sel_mode, m_sel_mode;
  logic [31:0] f_sel_addr, m_sel_addr;
  logic [31:0] f_sel_wdata, m_sel_wdata;
  logic [3:0]  f_sel_wstrb, m_sel_wstrb;
  logic        pick_mem;
  logic        grant;
  logic        a_mode;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic [3:0]  a_wstrb;
  logic        a_in_range;
  logic [ADDR_W-1:0] a_idx;
  logic        ram_we;

`ifdef BUS_RESP_ROUNDROBIN_EN
  // 1 = mem won the most recent tie, 0 = fetch did (reset value, so mem
  // takes the first tie).
  logic        last_mem_q, last_mem_d;
`endif

  // Request acceptance, eligibility and the field view used at grant time.
  // A request arriving in the same cycle it is granted is taken straight
  // from the input pins; an older one comes from its pending register.
  always_comb begin
    f_accept    = fetch_request_enable && !f_pend_q;
    m_accept    = mem_request_enable && !m_pend_q;
    f_elig      = f_pend_q || fetch_request_enable;
    m_elig      = m_pend_q || mem_request_enable;

    f_sel_mode  = f_pend_q ? f_mode_q  : freq_mode;
    f_sel_addr  = f_pend_q ? f_addr_q  : freq_addr;
    f_sel_wdata = f_pend_q ? f_wdata_q : freq_wdata;
    f_sel_wstrb = f_pend_q ? f_wstrb_q : freq_wstrb;
    m_sel_mode  = m_pend_q ? m_mode_q  : mreq_mode;
    m_sel_addr  = m_pend_q ? m_addr_q  : mreq_addr;
    m_sel_wdata = m_pend_q ? m_wdata_q : mreq_wdata;
    m_sel_wstrb = m_pend_q ? m_wstrb_q : mreq_wstrb;
  end

  // Arbitration and the RAM access performed on the grant edge. Addresses
  // with any bit set above the RAM window read as 0 and do not write.
  always_comb begin
`ifdef BUS_RESP_ROUNDROBIN_EN
    pick_mem   = m_elig && (!f_elig || !last_mem_q);
`else
    pick_mem   = m_elig;
`endif
    grant      = (state_q == IDLE) && (m_elig || f_elig);

    a_mode     = pick_mem ? m_sel_mode  : f_sel_mode;
    a_addr     = pick_mem ? m_sel_addr  : f_sel_addr;
    a_wdata    = pick_mem ? m_sel_wdata : f_sel_wdata;
    a_wstrb    = pick_mem ? m_sel_wstrb : f_sel_wstrb;
    a_in_range = ((a_addr >> (ADDR_W + 2)) == 32'd0);
    a_idx      = a_addr[ADDR_W+1:2];

    // Writes are blocked while reset is held so a request presented during
    // reset cannot corrupt memory.
    ram_we     = grant && a_mode && a_in_range && !rst;

    rdata_d    = rdata_q;
    if (grant) begin
      rdata_d = (!a_mode && a_in_range) ? ram_mem[a_idx] : 32'd0;
    end
  end

`ifdef BUS_RESP_ROUNDROBIN_EN
  // The last-served bit only moves on a real tie; uncontested grants leave
  // it alone so alternation is between contended pairs.
  always_comb begin
    last_mem_d = last_mem_q;
    if (grant && m_elig && f_elig) begin
      last_mem_d = pick_mem;
    end
  end
`endif

  // Next-state logic: grant in IDLE, count down in WAIT, one RESP cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_mem_d = gnt_mem_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          gnt_mem_d = pick_mem;
          cnt_d     = CNT_INIT;
          state_d   = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pending registers and the sticky overlap flag. A busy channel drops
  // any new request on it, including one arriving in its own RESP cycle.
  always_comb begin
    f_pend_d  = f_pend_q;
    f_mode_d  = f_mode_q;
    f_addr_d  = f_addr_q;
    f_wdata_d = f_wdata_q;
    f_wstrb_d = f_wstrb_q;
    m_pend_d  = m_pend_q;
    m_mode_d  = m_mode_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wstrb_d = m_wstrb_q;

    if (f_accept) begin
      f_pend_d  = 1'b1;
      f_mode_d  = freq_mode;
      f_addr_d  = freq_addr;
      f_wdata_d = freq_wdata;
      f_wstrb_d = freq_wstrb;
    end
    if (m_accept) begin
      m_pend_d  = 1'b1;
      m_mode_d  = mreq_mode;
      m_addr_d  = mreq_addr;
      m_wdata_d = mreq_wdata;
      m_wstrb_d = mreq_wstrb;
    end
    if (state_q == RESP) begin
      if (gnt_mem_q) begin
        m_pend_d = 1'b0;
      end else begin
        f_pend_d = 1'b0;
      end
    end

    err_d = err_q || (fetch_request_enable && f_pend_q)
                  || (mem_request_enable && m_pend_q);
  end

  // Response outputs, data forced to 0 outside the strobe cycle.
  always_comb begin
    fetch_response_enable = (state_q == RESP) && !gnt_mem_q;
    mem_response_enable   = (state_q == RESP) && gnt_mem_q;
    fresp_data            = fetch_response_enable ? rdata_q : 32'd0;
    mresp_data            = mem_response_enable ? rdata_q : 32'd0;
    err_overlap           = err_q;
  end

  // Control and request state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      gnt_mem_q <= 1'b0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
      f_pend_q  <= 1'b0;
      f_mode_q  <= 1'b0;
      f_addr_q  <= 32'd0;
      f_wdata_q <= 32'd0;
      f_wstrb_q <= 4'd0;
      m_pend_q  <= 1'b0;
      m_mode_q  <= 1'b0;
      m_addr_q  <= 32'd0;
      m_wdata_q <= 32'd0;
      m_wstrb_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_mem_q <= gnt_mem_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      f_pend_q  <= f_pend_d;
      f_mode_q  <= f_mode_d;
      f_addr_q  <= f_addr_d;
      f_wdata_q <= f_wdata_d;
      f_wstrb_q <= f_wstrb_d;
      m_pend_q  <= m_pend_d;
      m_mode_q  <= m_mode_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wstrb_q <= m_wstrb_d;
    end
  end

`ifdef BUS_RESP_ROUNDROBIN_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_mem_q <= 1'b0;
    end else begin
      last_mem_q <= last_mem_d;
    end
  end
`endif

  // RAM array with per-byte write enables; contents survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we && a_wstrb[i]) begin
        ram_mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_core_bus_responder.sv
// tb_core_bus_responder
//   Scoreboard bench for core_bus_responder. Two instances are used: one
//   with LATENCY = 2 exercising both channels, and one with LATENCY = 1 on
//   the mem channel. Expected responses (data and cycle) are queued when a
//   request is driven and checked when the response strobe appears.
module tb_core_bus_responder;

  localparam int AW = 12;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  int          cyc;

  logic        fetch_request_enable;
  logic        freq_mode;
  logic [31:0] freq_addr;
  logic [31:0] freq_wdata;
  logic [3:0]  freq_wstrb;
  logic        fetch_response_enable;
  logic [31:0] fresp_data;
  logic        mem_request_enable;
  logic        mreq_mode;
  logic [31:0] mreq_addr;
  logic [31:0] mreq_wdata;
  logic [3:0]  mreq_wstrb;
  logic        mem_response_enable;
  logic [31:0] mresp_data;
  logic        err_overlap;

  logic        l1_mem_en;
  logic        l1_mode;
  logic [31:0] l1_addr;
  logic [31:0] l1_wdata;
  logic [3:0]  l1_wstrb;
  logic        l1_mresp_en;
  logic [31:0] l1_mresp_data;
  logic        l1_fresp_en;
  logic [31:0] l1_fresp_data;
  logic        l1_err;
  logic        l1_f_en;
  logic        l1_f_mode;
  logic [31:0] l1_f_addr;
  logic [31:0] l1_f_wdata;
  logic [3:0]  l1_f_wstrb;

  exp_t q_f[$];
  exp_t q_m[$];
  exp_t q_l[$];
  logic [31:0] model_a [int];
  logic [31:0] model_b [int];

  int compared;
  int mismatched;

  core_bus_responder #(.ADDR_W(AW), .LATENCY(2)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .fetch_request_enable  (fetch_request_enable),
    .freq_mode             (freq_mode),
    .freq_addr             (freq_addr),
    .freq_wdata            (freq_wdata),
    .freq_wstrb            (freq_wstrb),
    .fetch_response_enable (fetch_response_enable),
    .fresp_data            (fresp_data),
    .mem_request_enable    (mem_request_enable),
    .mreq_mode             (mreq_mode),
    .mreq_addr             (mreq_addr),
    .mreq_wdata            (mreq_wdata),
    .mreq_wstrb            (mreq_wstrb),
    .mem_response_enable   (mem_response_enable),
    .mresp_data            (mresp_data),
    .err_overlap           (err_overlap)
  );

  core_bus_responder #(.ADDR_W(AW), .LATENCY(1)) dut_l1 (
    .clk                   (clk),
    .rst                   (rst),
    .fetch_request_enable  (l1_f_en),
    .freq_mode             (l1_f_mode),
    .freq_addr             (l1_f_addr),
    .freq_wdata            (l1_f_wdata),
    .freq_wstrb            (l1_f_wstrb),
    .fetch_response_enable (l1_fresp_en),
    .fresp_data            (l1_fresp_data),
    .mem_request_enable    (l1_mem_en),
    .mreq_mode             (l1_mode),
    .mreq_addr             (l1_addr),
    .mreq_wdata            (l1_wdata),
    .mreq_wstrb            (l1_wstrb),
    .mem_response_enable   (l1_mresp_en),
    .mresp_data            (l1_mresp_data),
    .err_overlap           (l1_err)
  );

  // Free-running clock and cycle counter; cycle N starts at the Nth edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
               tag, actual, expected, cyc);
    end
  endtask

  function automatic int qSize(input int ch);
    case (ch)
      0:       return q_f.size();
      1:       return q_m.size();
      default: return q_l.size();
    endcase
  endfunction

  function automatic exp_t qFront(input int ch);
    case (ch)
      0:       return q_f[0];
      1:       return q_m[0];
      default: return q_l[0];
    endcase
  endfunction

  task automatic qPop(input int ch);
    case (ch)
      0:       void'(q_f.pop_front());
      1:       void'(q_m.pop_front());
      default: void'(q_l.pop_front());
    endcase
  endtask

  // Reference memory: ch 0/1 share the LATENCY=2 instance, ch 2 is the
  // LATENCY=1 instance. Out-of-window addresses read 0 and never write.
  task automatic modelAccess(input int ch, input logic mode,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb,
                             output logic [31:0] result);
    int          idx;
    logic [31:0] word;
    idx    = int'(addr[AW+1:2]);
    result = 32'd0;
    if ((addr >> (AW + 2)) != 32'd0) return;
    if (ch == 2) word = model_b.exists(idx) ? model_b[idx] : 32'hxxxxxxxx;
    else         word = model_a.exists(idx) ? model_a[idx] : 32'hxxxxxxxx;
    if (mode) begin
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) word[8*b +: 8] = wdata[8*b +: 8];
      if (ch == 2) model_b[idx] = word;
      else         model_a[idx] = word;
    end else begin
      result = word;
    end
  endtask

  // Drive one request in the current cycle and queue its expected response
  // at cycle (now + resp_delay).
  task automatic applyStimulus(input int ch, input logic mode,
                               input logic [31:0] addr,
                               input logic [31:0] wdata,
                               input logic [3:0] wstrb,
                               input int resp_delay);
    exp_t e;
    modelAccess(ch, mode, addr, wdata, wstrb, e.data);
    e.cyc = cyc + resp_delay;
    case (ch)
      0: begin
        fetch_request_enable = 1'b1; freq_mode = mode; freq_addr = addr;
        freq_wdata = wdata; freq_wstrb = wstrb; q_f.push_back(e);
      end
      1: begin
        mem_request_enable = 1'b1; mreq_mode = mode; mreq_addr = addr;
        mreq_wdata = wdata; mreq_wstrb = wstrb; q_m.push_back(e);
      end
      default: begin
        l1_mem_en = 1'b1; l1_mode = mode; l1_addr = addr;
        l1_wdata = wdata; l1_wstrb = wstrb; q_l.push_back(e);
      end
    endcase
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      fetch_request_enable = 1'b0;
      mem_request_enable   = 1'b0;
      l1_mem_en            = 1'b0;
    end
  endtask

  // Compare one response channel against its queue; a response that has
  // not appeared by its expected cycle is reported and dropped.
  task automatic monitorChan(input int ch, input string name,
                             input logic strobe, input logic [31:0] data);
    exp_t e;
    bit   have;
    have = (qSize(ch) > 0);
    if (have) e = qFront(ch);
    if (strobe) begin
      if (!have) begin
        checkOutput({name, "_unexpected"}, 32'(strobe), 32'd0);
      end else begin
        qPop(ch);
        checkOutput({name, "_data"}, data, e.data);
        checkOutput({name, "_cycle"}, cyc, e.cyc);
      end
    end else begin
      checkOutput({name, "_idle_data"}, data, 32'd0);
      if (have && cyc >= e.cyc) begin
        checkOutput({name, "_strobe"}, 32'(strobe), 32'd1);
        qPop(ch);
      end
    end
  endtask

  always @(negedge clk) begin
    monitorChan(0, "fetch", fetch_response_enable, fresp_data);
    monitorChan(1, "mem", mem_response_enable, mresp_data);
    monitorChan(2, "l1_mem", l1_mresp_en, l1_mresp_data);
    checkOutput("l1_fetch_strobe", 32'(l1_fresp_en), 32'd0);
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    fetch_request_enable = 0; freq_mode = 0; freq_addr = 0;
    freq_wdata = 0; freq_wstrb = 0;
    mem_request_enable = 0; mreq_mode = 0; mreq_addr = 0;
    mreq_wdata = 0; mreq_wstrb = 0;
    l1_mem_en = 0; l1_mode = 0; l1_addr = 0; l1_wdata = 0; l1_wstrb = 0;
    l1_f_en = 0; l1_f_mode = 0; l1_f_addr = 0; l1_f_wdata = 0; l1_f_wstrb = 0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_fetch_en", 32'(fetch_response_enable), 32'd0);
    checkOutput("rst_mem_en", 32'(mem_response_enable), 32'd0);
    checkOutput("rst_fresp_data", fresp_data, 32'd0);
    checkOutput("rst_mresp_data", mresp_data, 32'd0);
    checkOutput("rst_err", 32'(err_overlap), 32'd0);
    step(1);

    $display("[TB] preload through mem writes");
    applyStimulus(1, 1'b1, 32'h14, 32'hDEADBEEF, 4'hF, 2); step(3);
    applyStimulus(1, 1'b1, 32'h20, 32'hAAAAAAAA, 4'hF, 2); step(3);
    applyStimulus(1, 1'b1, 32'h00, 32'h01234567, 4'hF, 2); step(3);
    applyStimulus(1, 1'b1, 32'h04, 32'h89ABCDEF, 4'hF, 2); step(3);

    $display("[TB] fetch read latency");
    applyStimulus(0, 1'b0, 32'h14, 32'd0, 4'h0, 2); step(3);

    $display("[TB] partial writes");
    applyStimulus(1, 1'b1, 32'h20, 32'h11223344, 4'b0101, 2); step(3);
    applyStimulus(1, 1'b0, 32'h20, 32'd0, 4'h0, 2); step(3);
    applyStimulus(1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 2); step(3);
    applyStimulus(1, 1'b0, 32'h23, 32'd0, 4'h0, 2); step(3);

    $display("[TB] simultaneous requests");
    applyStimulus(0, 1'b0, 32'h00, 32'd0, 4'h0, 5);
    applyStimulus(1, 1'b0, 32'h04, 32'd0, 4'h0, 2);
    step(6);
`ifdef BUS_RESP_ROUNDROBIN_EN
    applyStimulus(0, 1'b0, 32'h00, 32'd0, 4'h0, 2);
    applyStimulus(1, 1'b0, 32'h04, 32'd0, 4'h0, 5);
`else
    applyStimulus(0, 1'b0, 32'h00, 32'd0, 4'h0, 5);
    applyStimulus(1, 1'b0, 32'h04, 32'd0, 4'h0, 2);
`endif
    step(6);

    $display("[TB] overlap");
    applyStimulus(0, 1'b0, 32'h00, 32'd0, 4'h0, 2);
    step(1);
    checkOutput("err_before_overlap", 32'(err_overlap), 32'd0);
    fetch_request_enable = 1'b1; freq_mode = 1'b0; freq_addr = 32'h04;
    step(1);
    checkOutput("err_set", 32'(err_overlap), 32'd1);
    step(2);
    checkOutput("err_sticky", 32'(err_overlap), 32'd1);
    applyStimulus(0, 1'b0, 32'h04, 32'd0, 4'h0, 2);
    step(2);
    fetch_request_enable = 1'b1; freq_mode = 1'b0; freq_addr = 32'h00;
    step(4);

    $display("[TB] out-of-range accesses");
    applyStimulus(0, 1'b0, 32'h0001_0000, 32'd0, 4'h0, 2); step(3);
    applyStimulus(1, 1'b1, 32'h0001_0014, 32'h0, 4'hF, 2); step(3);
    applyStimulus(1, 1'b0, 32'h14, 32'd0, 4'h0, 2); step(3);

    $display("[TB] reset mid-flight");
    applyStimulus(1, 1'b0, 32'h14, 32'd0, 4'h0, 2);
    step(1);
    rst = 1'b1;
    void'(q_m.pop_back());
    step(1);
    rst = 1'b0;
    step(4);
    checkOutput("err_after_reset", 32'(err_overlap), 32'd0);
    applyStimulus(1, 1'b1, 32'h24, 32'h5A5A1234, 4'hF, 2);
    step(1);
    rst = 1'b1;
    void'(q_m.pop_back());
    step(1);
    rst = 1'b0;
    step(2);
    applyStimulus(1, 1'b0, 32'h14, 32'd0, 4'h0, 2); step(3);
    applyStimulus(0, 1'b0, 32'h20, 32'd0, 4'h0, 2); step(3);
    applyStimulus(0, 1'b0, 32'h24, 32'd0, 4'h0, 2); step(3);

    $display("[TB] LATENCY = 1 instance");
    applyStimulus(2, 1'b1, 32'h08, 32'hCAFEF00D, 4'hF, 1); step(2);
    applyStimulus(2, 1'b0, 32'h08, 32'd0, 4'h0, 1); step(2);
    applyStimulus(2, 1'b1, 32'h08, 32'h000000EE, 4'b0001, 1); step(2);
    applyStimulus(2, 1'b0, 32'h08, 32'd0, 4'h0, 1); step(2);
    checkOutput("l1_err", 32'(l1_err), 32'd0);

    for (int i = 0; i < 40 && (q_f.size() + q_m.size() + q_l.size()) != 0; i++)
      step(1);
    checkOutput("drain_fetch", q_f.size(), 32'd0);
    checkOutput("drain_mem", q_m.size(), 32'd0);
    checkOutput("drain_l1", q_l.size(), 32'd0);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/core_bus_responder.md
Name: core_bus_responder

Overview:
- Target-side counterpart to the core's two request/response bus channels (fetch and mem).
- Accepts single-cycle request pulses on each channel and holds one pending request per channel.
- Arbitrates the two channels onto a single internal word-addressed RAM and returns one single-cycle response pulse per request.
- Serves as the simulation and FPGA memory model behind the core.

Parameters:
- ADDR_W, 12, RAM word-address width; RAM holds 2^ADDR_W 32-bit words.
- LATENCY, 2, cycles from grant to response pulse; legal range 1..15.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- fetch_request_enable  in  1  fetch request strobe, one cycle per request
- freq_mode  in  1  0 = read, 1 = write
- freq_addr  in  32  byte address
- freq_wdata  in  32  write data
- freq_wstrb  in  4  byte enables; bit i enables byte i
- fetch_response_enable  out  1  one-cycle fetch response strobe
- fresp_data  out  32  fetch read data, valid while the strobe is high
- mem_request_enable  in  1  mem request strobe
- mreq_mode  in  1  0 = read, 1 = write
- mreq_addr  in  32  byte address
- mreq_wdata  in  32  write data
- mreq_wstrb  in  4  byte enables
- mem_response_enable  out  1  one-cycle mem response strobe
- mresp_data  out  32  mem read data
- err_overlap  out  1  sticky protocol-violation flag

Behaviour:
- Reset: all outputs are 0, pending flags are cleared, FSM is in IDLE. RAM contents are not reset.
- Reset asserted mid-operation: the in-flight request is abandoned and no response is issued. A write already committed stays committed.
- Capture:
  - A request's mode, addr, wdata and wstrb are sampled only in the cycle its enable is high.
  - Sampled fields go into that channel's pending register.
  - Inputs are don't-care at all other times.
- Overlap:
  - A request arriving on a channel that already has a pending or in-service request is dropped.
  - err_overlap is set to 1 and stays set until reset.
- Addressing:
  - Word index is addr[ADDR_W+1:2]; addr[1:0] is ignored.
  - If addr[31:ADDR_W+2] is nonzero: reads return 0, writes are ignored, a response is still issued.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If any request is eligible, grant one and perform the access at that edge.
  - Eligible means pending, or arriving this cycle (same-cycle grant allowed).
  - Fixed priority: mem before fetch.
  - Write: merge wdata into the RAM word per wstrb. wstrb = 0000 leaves the word unchanged.
  - Read: capture the RAM word into a data register.
  - Next state is WAIT with counter = LATENCY-2, or RESP directly if LATENCY = 1.
- WAIT: decrement the counter; when it reaches 0, go to RESP.
- RESP:
  - Drive the granted channel's response_enable = 1 for exactly one cycle.
  - Data output = read word, or 0 for writes.
  - Clear that channel's pending flag. Next state is IDLE.
- Data outputs are 0 whenever their strobe is low.
- Timing:
  - Request in cycle 0 with FSM in IDLE → response in cycle LATENCY.
  - Back-to-back service period is LATENCY+1 cycles.
- Simultaneous fetch and mem requests: mem is served first; fetch stays pending and is granted in the first IDLE cycle after mem's RESP.
- A same-channel request arriving during that channel's RESP cycle counts as overlap. The core must wait for the response.
- A read granted after a write sees the written data.

Optional Feature:
- Macro: BUS_RESP_ROUNDROBIN_EN.
- Defined:
  - Arbitration is round-robin: a 1-bit last-served register selects the other channel when both are eligible.
  - The register resets to "fetch served", so mem wins the first tie.
- Undefined: fixed mem-over-fetch priority as described above.
- All other behaviour is identical.

Test Plan:
1. Read latency: LATENCY = 2, RAM word 5 = 0xDEADBEEF. Fetch read addr 0x14 in cycle 0 → fetch_response_enable high only in cycle 2, fresp_data = 0xDEADBEEF, fresp_data = 0 in cycles 1 and 3.
2. Partial write: mem write addr 0x20, wdata 0x11223344, wstrb 0101 over word 0xAAAAAAAA → mresp_data = 0 on response. A following mem read of 0x20 returns 0xAA22AA44.
3. Arbitration: fetch read 0x0 and mem read 0x4 both in cycle 0, LATENCY = 2 → mem response in cycle 2, fetch response in cycle 5. With BUS_RESP_ROUNDROBIN_EN, a second simultaneous pair sent after both responses is served fetch first.
4. Overlap and out-of-range: a second fetch request in cycle 1 while the cycle-0 fetch is in service → only one fetch response, err_overlap = 1 from cycle 2 and it persists. A read of 0x0001_0000 with ADDR_W = 12 returns 0.
5. Reset mid-flight: assert rst in cycle 1 of a mem read → no mem_response_enable ever, err_overlap = 0. A new request after reset is served normally, and RAM contents are unchanged.
6. LATENCY = 1: mem read in cycle 0 → response in cycle 1. A second mem request in cycle 2 → response in cycle 3.
